// File: rtl/mvu_pkg.sv
// ============================================================================
// Module : mvu_pkg
// Brief  : MVU array constants and APB arbiter state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mvu_pkg;
   localparam int NMVU            = 8;
   localparam int APB_ARB_TIMEOUT = 256;

   typedef enum logic [1:0] {
      APB_ARB_IDLE   = 2'd0,
      APB_ARB_SETUP  = 2'd1,
      APB_ARB_ACCESS = 2'd2,
      APB_ARB_RESP   = 2'd3
   } apb_arb_state_t;
endpackage

`default_nettype wire

// File: rtl/pito_pkg.sv
// ============================================================================
// Module : pito_pkg
// Brief  : pito SoC APB bus widths shared with the MVU configuration path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pito_pkg;
   localparam int APB_ADDR_WIDTH = 32;
   localparam int APB_DATA_WIDTH = 32;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker; first set request at or after
//          ptr_i, wrapping to 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 8
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       valid_o
);
   localparam int IW = $clog2(NUM_REQ);

   int            j;
   logic [IW-1:0] jj;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      jj      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = IW'(j);
         if (!valid_o && req_i[jj]) begin
            valid_o   = 1'b1;
            gnt_o[jj] = 1'b1;
            idx_o     = jj;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/mvu_apb_arbiter.sv
// ============================================================================
// Module : mvu_apb_arbiter
// Brief  : Round-robin sharing of the MVU configuration APB slave between
//          NUM_REQ requesters. Optional ACCESS watchdog: MVU_APB_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvu_apb_arbiter
   import mvu_pkg::*;
#(
   parameter int NUM_REQ        = mvu_pkg::NMVU,
   parameter int ADDR_WIDTH     = pito_pkg::APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = pito_pkg::APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = mvu_pkg::APB_ARB_TIMEOUT
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_psel,
   input  logic [NUM_REQ-1:0]             req_pwrite,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_paddr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_pwdata,
   output logic [NUM_REQ-1:0]             req_pready,
   output logic [DATA_WIDTH-1:0]          req_prdata,
   output logic [NUM_REQ-1:0]             req_pslverr,
   output logic                           m_psel,
   output logic                           m_penable,
   output logic                           m_pwrite,
   output logic [ADDR_WIDTH-1:0]          m_paddr,
   output logic [DATA_WIDTH-1:0]          m_pwdata,
   input  logic [DATA_WIDTH-1:0]          m_prdata,
   input  logic                           m_pready,
   input  logic                           m_pslverr,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id
);
   localparam int IW = $clog2(NUM_REQ);

   localparam logic [1:0] ST_IDLE   = APB_ARB_IDLE;
   localparam logic [1:0] ST_SETUP  = APB_ARB_SETUP;
   localparam logic [1:0] ST_ACCESS = APB_ARB_ACCESS;
   localparam logic [1:0] ST_RESP   = APB_ARB_RESP;

   logic [1:0]            state_q,  state_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]         grant_q,  grant_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
   logic                  write_q,  write_d;
   logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
   logic                  err_q,    err_d;

   logic [NUM_REQ-1:0]    w_gnt;
   logic [IW-1:0]         w_idx;
   logic                  w_valid;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i   (req_psel),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (w_gnt),
      .idx_o   (w_idx),
      .valid_o (w_valid)
   );

`ifdef MVU_APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          w_timeout;

   // cnt_q counts completed ACCESS cycles, so this fires in the last allowed one
   assign w_timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
`ifdef MVU_APB_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_valid) begin
               state_d = ST_SETUP;
               grant_d = w_idx;
               addr_d  = req_paddr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d = req_pwdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
               write_d = |(req_pwrite & w_gnt);
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
`ifdef MVU_APB_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_ACCESS: begin
`ifdef MVU_APB_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (m_pready) begin
               rdata_d = m_prdata;
               err_d   = m_pslverr;
               state_d = ST_RESP;
            end
`ifdef MVU_APB_ARB_TIMEOUT_EN
            else if (w_timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
`ifdef MVU_APB_ARB_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
`ifdef MVU_APB_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Outputs decode from registered state only, so they are glitch-free
   assign m_psel     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign m_penable  = (state_q == ST_ACCESS);
   assign m_pwrite   = m_psel & write_q;
   assign m_paddr    = m_psel ? addr_q  : '0;
   assign m_pwdata   = m_psel ? wdata_q : '0;
   assign busy       = (state_q != ST_IDLE);
   assign grant_id   = grant_q;
   assign req_prdata = (state_q == ST_RESP) ? rdata_q : '0;

   always_comb begin
      req_pready  = '0;
      req_pslverr = '0;
      if (state_q == ST_RESP) begin
         req_pready[grant_q]  = 1'b1;
         req_pslverr[grant_q] = err_q;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_mvu_apb_arbiter.sv
// ============================================================================
// Module : tb_mvu_apb_arbiter
// Brief  : Directed bench for mvu_apb_arbiter with a configurable APB slave.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvu_apb_arbiter;
   localparam int N  = 8;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_psel, req_pwrite;
   logic [N*AW-1:0] req_paddr;
   logic [N*DW-1:0] req_pwdata;
   logic [N-1:0]    req_pready, req_pslverr;
   logic [DW-1:0]   req_prdata;
   logic            m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
   logic [AW-1:0]   m_paddr;
   logic [DW-1:0]   m_pwdata, m_prdata;
   logic            busy;
   logic [2:0]      grant_id;

   int          n_cmp = 0;
   int          n_err = 0;

   int          acc_cnt = 0;
   int          cfg_wait = 0;
   logic        cfg_hang = 1'b0;
   logic [31:0] cfg_rdata = '0;
   logic        cfg_err = 1'b0;
   logic [31:0] seen_addr = '0, seen_wdata = '0;
   logic        seen_write = 1'b0;

   always #5 clk = ~clk;

   mvu_apb_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_psel(req_psel), .req_pwrite(req_pwrite),
      .req_paddr(req_paddr), .req_pwdata(req_pwdata),
      .req_pready(req_pready), .req_prdata(req_prdata), .req_pslverr(req_pslverr),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
      .busy(busy), .grant_id(grant_id)
   );

   // APB slave: inserts cfg_wait wait states, or never answers when cfg_hang
   assign m_pready  = m_psel && m_penable && !cfg_hang && (acc_cnt >= cfg_wait);
   assign m_prdata  = cfg_rdata;
   assign m_pslverr = cfg_err;

   always @(posedge clk) begin
      if (m_psel && m_penable) acc_cnt <= acc_cnt + 1;
      else                     acc_cnt <= 0;
      if (m_psel && m_penable && m_pready) begin
         seen_addr  <= m_paddr;
         seen_wdata <= m_pwdata;
         seen_write <= m_pwrite;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc1();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_txn(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input logic er,
                         input logic [31:0] exp_rd, input logic exp_er, input int exp_cyc,
                         input logic hang);
      int   cyc;
      logic got;
      cfg_wait  = waits;
      cfg_rdata = rd;
      cfg_err   = er;
      cfg_hang  = hang;
      req_pwrite[r]          = w;
      req_paddr[r*AW +: AW]  = a;
      req_pwdata[r*DW +: DW] = d;
      req_psel[r]            = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 60) begin
         cyc1();
         cyc++;
         if (cyc == 1) begin
            check("setup_ctl", {30'd0, m_psel, m_penable}, 32'h2);
            check("setup_addr", m_paddr, a);
         end
         if (req_pready != '0) got = 1'b1;
      end
      check("resp_seen", {31'd0, got}, 32'd1);
      check("resp_cycle", cyc, exp_cyc);
      check("resp_pready", {24'd0, req_pready}, 32'd1 << r);
      check("resp_prdata", req_prdata, exp_rd);
      check("resp_pslverr", {24'd0, req_pslverr}, 32'(exp_er) << r);
      check("resp_grant", {29'd0, grant_id}, r);
      if (!hang) begin
         check("slv_addr", seen_addr, a);
         check("slv_wdata", seen_wdata, d);
         check("slv_write", {31'd0, seen_write}, {31'd0, w});
      end
      req_psel[r] = 1'b0;
      cfg_hang    = 1'b0;
      cyc1();
      check("post_prdata", req_prdata, 32'd0);
      check("post_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc1();
      cyc1();
      rst_n = 1'b1;
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_ctl"}, {16'd0, m_psel, m_penable, m_pwrite, busy, req_pready, req_pslverr}, 32'd0);
      check({nm, "_paddr"}, m_paddr, 32'd0);
      check({nm, "_pwdata"}, m_pwdata, 32'd0);
      check({nm, "_prdata"}, req_prdata, 32'd0);
      check({nm, "_grant"}, {29'd0, grant_id}, 32'd0);
   endtask

   typedef struct {
      int          r;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      int          waits;
      logic [31:0] rd;
      logic        er;
      logic [31:0] exp_rd;
      logic        exp_er;
      int          exp_cyc;
   } vec_t;

   vec_t tv[6];
   int   order[8];
   int   gcyc[8];
   int   exp_wrap[3];
   int   ng, cyc, stray;

   initial begin
      tv[0] = '{2, 1'b1, 32'h20, 32'hA5A5_0001, 0, 32'h0,         1'b0, 32'h0,         1'b0, 3};
      tv[1] = '{0, 1'b0, 32'h44, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 6};
      tv[2] = '{5, 1'b1, 32'h10, 32'h5555_AAAA, 0, 32'h0,         1'b1, 32'h0,         1'b1, 3};
      tv[3] = '{7, 1'b0, 32'hFC, 32'h0,         1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 4};
      tv[4] = '{3, 1'b1, 32'h88, 32'hCAFE_F00D, 2, 32'h0,         1'b0, 32'h0,         1'b0, 5};
      tv[5] = '{1, 1'b0, 32'h04, 32'h0,         0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1, 3};
      exp_wrap = '{0, 5, 0};

      rst_n      = 1'b0;
      req_psel   = '0;
      req_pwrite = '0;
      req_paddr  = '0;
      req_pwdata = '0;
      @(negedge clk);
      cyc1();
      cyc1();
      check_all_zero("reset");
      rst_n = 1'b1;
      cyc1();

      for (int i = 0; i < 6; i++)
         do_txn(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].waits, tv[i].rd, tv[i].er,
                tv[i].exp_rd, tv[i].exp_er, tv[i].exp_cyc, 1'b0);

      // Contention from a fresh pointer: all eight at once
      do_reset();
      cfg_wait = 0;
      cfg_err  = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_paddr[i*AW +: AW] = 32'h100 + 32'(i * 4);
         order[i] = -1;
         gcyc[i]  = 0;
      end
      req_psel = '1;
      ng  = 0;
      cyc = 0;
      while (ng < 8 && cyc < 80) begin
         cyc1();
         cyc++;
         if (req_pready != '0) begin
            check("cont_onehot", $countones(req_pready), 32'd1);
            for (int i = 0; i < N; i++)
               if (req_pready[i]) begin
                  order[ng]   = i;
                  gcyc[ng]    = cyc;
                  req_psel[i] = 1'b0;
               end
            ng++;
         end
      end
      check("cont_count", ng, 32'd8);
      for (int k = 0; k < 8; k++) begin
         check("cont_order", order[k], k);
         if (k == 0) check("cont_first", gcyc[0], 32'd3);
         else        check("cont_gap", gcyc[k] - gcyc[k-1], 32'd4);
      end
      req_psel = '0;
      cyc1();

      // Pointer wrapped to 0; held requests re-arbitrate each completion
      req_psel[0] = 1'b1;
      req_psel[5] = 1'b1;
      ng  = 0;
      cyc = 0;
      while (ng < 3 && cyc < 40) begin
         cyc1();
         cyc++;
         if (req_pready != '0) begin
            for (int i = 0; i < N; i++)
               if (req_pready[i]) check("wrap_order", i, exp_wrap[ng]);
            ng++;
            if (ng == 3) req_psel = '0;
         end
      end
      check("wrap_count", ng, 32'd3);
      cyc1();

      // Reset in ACCESS abandons the transfer
      cfg_hang = 1'b1;
      req_paddr[4*AW +: AW] = 32'h40;
      req_psel[4] = 1'b1;
      cyc1();
      cyc1();
      check("rst_in_access", {30'd0, m_psel, m_penable}, 32'h3);
      rst_n    = 1'b0;
      req_psel = '0;
      cyc1();
      check_all_zero("rst_mid");
      rst_n    = 1'b1;
      cfg_hang = 1'b0;
      stray    = 0;
      for (int i = 0; i < 6; i++) begin
         cyc1();
         if (req_pready != '0 || busy) stray++;
      end
      check("rst_no_pready", stray, 32'd0);

`ifdef MVU_APB_ARB_TIMEOUT_EN
      do_txn(6, 1'b0, 32'h60, 32'h0, 0, 32'h7777_7777, 1'b0, 32'h0, 1'b1, 18, 1'b1);
      do_txn(6, 1'b0, 32'h64, 32'h0, 0, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 3, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

`default_nettype wire
